// File: rtl/temp_pkg.sv
// Shared definitions for the PT100 temperature sampling path.
//   state_e     : sampling controller FSM states
//   TEMP_W      : width of the published temperature in degrees C
//   PT100_SCALE : multiplier applied to the averaged ADC code
//   PT100_SHIFT : right shift applied after the multiply (divide by 1024)
package temp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_CONV,
        ST_OUTPUT
    } state_e;

    localparam int unsigned TEMP_W      = 8;
    localparam int unsigned PT100_SCALE = 165;
    localparam int unsigned PT100_SHIFT = 10;

endpackage : temp_pkg

// File: rtl/pt100.sv
// PT100 scaling: converts an averaged ADC code to whole degrees C.
// temp = (avg * PT100_SCALE) >> PT100_SHIFT, truncated. Purely combinational;
// the caller registers the result.
// Ports:
//   avg_i  [ADC_RES-1:0] : averaged ADC code
//   temp_o [TEMP_W-1:0]  : temperature in degrees C
module pt100
    import temp_pkg::*;
#(
    parameter int unsigned ADC_RES = 10
) (
    input  logic [ADC_RES-1:0] avg_i,
    output logic [TEMP_W-1:0]  temp_o
);

    // Wide enough for the full product so the multiply never wraps.
    localparam int unsigned PROD_W = ADC_RES + $clog2(PT100_SCALE + 1);

    logic [PROD_W-1:0] prod;

    assign prod   = PROD_W'(avg_i) * PROD_W'(PT100_SCALE);
    assign temp_o = TEMP_W'(prod >> PT100_SHIFT);

endmodule : pt100

// File: rtl/temp_sample_ctrl.sv
// Periodic sampling controller for the PT100 temperature path.
// Paces ADC conversions every CLK_DIV cycles, averages 2**AVG_LOG2 samples,
// scales the average to degrees through pt100 and publishes a registered
// temperature with a valid strobe, a hysteresis alarm and a sticky timeout flag.
// Ports:
//   clk_i         : clock, rising edge
//   rst_ni        : asynchronous active-low reset
//   en_i          : enable; low aborts the current cycle and idles
//   adc_data_i    : conversion result, valid while adc_done_i is high
//   adc_done_i    : conversion-complete flag (only sampled in CONV)
//   adc_start_o   : one-cycle conversion start pulse
//   thr_hi_i      : alarm set threshold, degrees C
//   thr_lo_i      : alarm clear threshold, degrees C
//   temp_o        : last averaged temperature, degrees C
//   temp_valid_o  : one-cycle strobe when temp_o updates
//   alarm_o       : hysteresis over-temperature alarm
//   err_o         : sticky conversion-timeout flag (cleared while en_i is low)
module temp_sample_ctrl
    import temp_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 1023,
    parameter int unsigned ADC_RES  = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [ADC_RES-1:0] adc_data_i,
    input  logic               adc_done_i,
    output logic               adc_start_o,
    input  logic [TEMP_W-1:0]  thr_hi_i,
    input  logic [TEMP_W-1:0]  thr_lo_i,
    output logic [TEMP_W-1:0]  temp_o,
    output logic               temp_valid_o,
    output logic               alarm_o,
    output logic               err_o
);

    localparam int unsigned N_SAMPLES = 1 << AVG_LOG2;
    localparam int unsigned ACC_W     = ADC_RES + AVG_LOG2;   // sum of N_SAMPLES codes never overflows
    localparam int unsigned SMP_W     = AVG_LOG2 + 1;
    localparam int unsigned PER_W     = $clog2(CLK_DIV);
    localparam int unsigned TO_W      = $clog2(TIMEOUT + 1);

    state_e               state_q,      state_d;
    logic [PER_W-1:0]     per_cnt_q,    per_cnt_d;
    logic [TO_W-1:0]      to_cnt_q,     to_cnt_d;
    logic [ACC_W-1:0]     acc_q,        acc_d;
    logic [SMP_W-1:0]     smp_q,        smp_d;
    logic                 adc_start_q,  adc_start_d;
    logic [TEMP_W-1:0]    temp_q,       temp_d;
    logic                 temp_valid_q, temp_valid_d;
    logic                 alarm_q,      alarm_d;
    logic                 err_q,        err_d;

    logic                 tick;
    logic [ADC_RES-1:0]   avg;
    logic [TEMP_W-1:0]    temp_new;

    assign tick = en_i && (per_cnt_q == PER_W'(CLK_DIV - 1));

    // Truncating average; the accumulator is complete by the time OUTPUT is entered.
    assign avg = ADC_RES'(acc_q >> AVG_LOG2);

    pt100 #(
        .ADC_RES (ADC_RES)
    ) u_pt100 (
        .avg_i  (avg),
        .temp_o (temp_new)
    );

    always_comb begin
        // NOTE: every _d signal gets its default before any branch so that no
        // path through this block leaves it unassigned and infers a latch.
        state_d      = state_q;
        per_cnt_d    = per_cnt_q;
        to_cnt_d     = to_cnt_q;
        acc_d        = acc_q;
        smp_d        = smp_q;
        adc_start_d  = 1'b0;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        alarm_d      = alarm_q;
        err_d        = err_q;

        // The period counter runs independently of the FSM, so ticks that land
        // outside WAIT are simply lost and the start cadence stays fixed.
        if (!en_i || tick) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + PER_W'(1);
        end

        if (!en_i) begin
            // Abort: temp and alarm keep their last published values.
            state_d  = ST_IDLE;
            to_cnt_d = '0;
            acc_d    = '0;
            smp_d    = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick) begin
                        state_d     = ST_START;
                        adc_start_d = 1'b1;   // registered, so high exactly during START
                    end
                end
                ST_START: begin
                    state_d  = ST_CONV;
                    to_cnt_d = '0;
                end
                ST_CONV: begin
                    if (adc_done_i) begin
                        acc_d    = acc_q + ACC_W'(adc_data_i);
                        smp_d    = smp_q + SMP_W'(1);
                        to_cnt_d = '0;
                        state_d  = (smp_q == SMP_W'(N_SAMPLES - 1)) ? ST_OUTPUT : ST_WAIT;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        // TIMEOUT cycles spent in CONV without a done: drop the
                        // partial average and retry on the next tick.
                        err_d    = 1'b1;
                        acc_d    = '0;
                        smp_d    = '0;
                        to_cnt_d = '0;
                        state_d  = ST_WAIT;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    temp_d       = temp_new;
                    temp_valid_d = 1'b1;
                    // Set test first so an inverted threshold pair still raises the alarm.
                    if (temp_new > thr_hi_i) begin
                        alarm_d = 1'b1;
                    end else if (temp_new < thr_lo_i) begin
                        alarm_d = 1'b0;
                    end
                    acc_d   = '0;
                    smp_d   = '0;
                    state_d = ST_WAIT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // computed before this edge, independent of statement order.
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            per_cnt_q    <= '0;
            to_cnt_q     <= '0;
            acc_q        <= '0;
            smp_q        <= '0;
            adc_start_q  <= 1'b0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
            alarm_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_cnt_q    <= per_cnt_d;
            to_cnt_q     <= to_cnt_d;
            acc_q        <= acc_d;
            smp_q        <= smp_d;
            adc_start_q  <= adc_start_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            alarm_q      <= alarm_d;
            err_q        <= err_d;
        end
    end

    assign adc_start_o  = adc_start_q;
    assign temp_o       = temp_q;
    assign temp_valid_o = temp_valid_q;
    assign alarm_o      = alarm_q;
    assign err_o        = err_q;

endmodule : temp_sample_ctrl

// File: tb/tb_temp_sample_ctrl.sv
// Directed testbench for temp_sample_ctrl (CLK_DIV=8, AVG_LOG2=2, TIMEOUT=16).
// The ADC model answers a start pulse with a one-cycle done three cycles after
// the start, taking samples from a queue loaded by each scenario.
module tb_temp_sample_ctrl;
    import temp_pkg::*;

    localparam int unsigned CLK_DIV  = 8;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned TIMEOUT  = 16;
    localparam int unsigned ADC_RES  = 10;

    logic               clk_i = 1'b0;
    logic               rst_ni = 1'b1;
    logic               en_i = 1'b0;
    logic [ADC_RES-1:0] adc_data_i;
    logic               adc_done_i;
    logic               adc_start_o;
    logic [7:0]         thr_hi_i = 8'd255;
    logic [7:0]         thr_lo_i = 8'd0;
    logic [7:0]         temp_o;
    logic               temp_valid_o;
    logic               alarm_o;
    logic               err_o;

    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 cyc = 0;
    int                 valid_cnt = 0;
    int                 start_q[$];
    logic [ADC_RES-1:0] adc_q[$];
    bit                 adc_respond = 1'b1;

    temp_sample_ctrl #(
        .CLK_DIV  (CLK_DIV),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT),
        .ADC_RES  (ADC_RES)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .adc_data_i   (adc_data_i),
        .adc_done_i   (adc_done_i),
        .adc_start_o  (adc_start_o),
        .thr_hi_i     (thr_hi_i),
        .thr_lo_i     (thr_lo_i),
        .temp_o       (temp_o),
        .temp_valid_o (temp_valid_o),
        .alarm_o      (alarm_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial forever @(posedge clk_i) cyc++;

    // Monitor: start pulse times and valid strobe count, sampled mid-cycle.
    initial forever begin
        @(negedge clk_i);
        if (adc_start_o === 1'b1) start_q.push_back(cyc);
        if (temp_valid_o === 1'b1) valid_cnt++;
    end

    // ADC model: done sampled by the DUT three edges after the start edge.
    initial begin
        adc_done_i = 1'b0;
        adc_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1 && adc_respond) begin
                repeat (2) @(negedge clk_i);
                adc_data_i = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
                adc_done_i = 1'b1;
                @(negedge clk_i);
                adc_done_i = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Loads four samples, enables, waits (bounded) for one result, then disables.
    task automatic run_result(input logic [ADC_RES-1:0] s0, s1, s2, s3,
                              output logic [7:0] t, output bit got, output int en_cyc);
        adc_q.delete();
        adc_q.push_back(s0);
        adc_q.push_back(s1);
        adc_q.push_back(s2);
        adc_q.push_back(s3);
        @(negedge clk_i);
        en_i   = 1'b1;
        en_cyc = cyc;
        got    = 1'b0;
        t      = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk_i);
            if (temp_valid_o === 1'b1) begin
                got = 1'b1;
                t   = temp_o;
            end
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        #3 rst_ni = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (adc_start_o !== 1'b0) begin n_bad++; $display("FAIL reset adc_start_o: got %b want 0", adc_start_o); end
        n_cmp++; if (temp_o !== 8'd0) begin n_bad++; $display("FAIL reset temp_o: got %0d want 0", temp_o); end
        n_cmp++; if (temp_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset temp_valid_o: got %b want 0", temp_valid_o); end
        n_cmp++; if (alarm_o !== 1'b0) begin n_bad++; $display("FAIL reset alarm_o: got %b want 0", alarm_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL reset err_o: got %b want 0", err_o); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL reset state: got %0d want IDLE", dut.state_q); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_constant();
        logic [7:0] t;
        bit         got;
        int         ec, base_s, base_v;
        thr_hi_i = 8'd255;
        thr_lo_i = 8'd0;
        base_s = start_q.size();
        base_v = valid_cnt;
        run_result(10'd1023, 10'd1023, 10'd1023, 10'd1023, t, got, ec);
        n_cmp++; if (!got || t !== 8'd164) begin n_bad++; $display("FAIL const temp_o: got %0d (seen %0d) want 164", t, got); end
        n_cmp++; if (valid_cnt - base_v != 1) begin n_bad++; $display("FAIL const valid pulses: got %0d want 1", valid_cnt - base_v); end
        n_cmp++; if (start_q.size() - base_s != 4) begin n_bad++; $display("FAIL const start count: got %0d want 4", start_q.size() - base_s); end
        if (start_q.size() - base_s >= 4) begin
            n_cmp++; if (start_q[base_s] - ec != CLK_DIV) begin n_bad++; $display("FAIL const first start latency: got %0d want %0d", start_q[base_s] - ec, CLK_DIV); end
            for (int k = 1; k < 4; k++) begin
                n_cmp++;
                if (start_q[base_s + k] - start_q[base_s + k - 1] != CLK_DIV) begin
                    n_bad++;
                    $display("FAIL const start spacing %0d: got %0d want %0d", k, start_q[base_s + k] - start_q[base_s + k - 1], CLK_DIV);
                end
            end
        end
        n_cmp++; if (alarm_o !== 1'b0) begin n_bad++; $display("FAIL const alarm_o: got %b want 0", alarm_o); end
    endtask

    task automatic test_averaging();
        logic [7:0] t;
        bit         got;
        int         ec;
        run_result(10'd100, 10'd200, 10'd300, 10'd400, t, got, ec);
        n_cmp++; if (!got || t !== 8'd40) begin n_bad++; $display("FAIL avg mixed temp_o: got %0d (seen %0d) want 40", t, got); end
        run_result(10'd512, 10'd512, 10'd512, 10'd512, t, got, ec);
        n_cmp++; if (!got || t !== 8'd82) begin n_bad++; $display("FAIL avg 512 temp_o: got %0d (seen %0d) want 82", t, got); end
        // Sum 127 -> avg 31 (truncated) -> 4; a rounded average of 32 would give 5.
        run_result(10'd31, 10'd32, 10'd32, 10'd32, t, got, ec);
        n_cmp++; if (!got || t !== 8'd4) begin n_bad++; $display("FAIL avg truncate temp_o: got %0d (seen %0d) want 4", t, got); end
    endtask

    task automatic test_alarm();
        int         hi_t[6]  = '{100, 100, 100, 50, 82, 255};
        int         lo_t[6]  = '{80, 80, 80, 200, 82, 83};
        int         s0_t[6]  = '{1023, 512, 100, 512, 512, 512};
        int         s1_t[6]  = '{1023, 512, 200, 512, 512, 512};
        int         s2_t[6]  = '{1023, 512, 300, 512, 512, 512};
        int         s3_t[6]  = '{1023, 512, 400, 512, 512, 512};
        int         tmp_t[6] = '{164, 82, 40, 82, 82, 82};
        bit         alm_t[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] t;
        bit         got;
        int         ec;
        for (int r = 0; r < 6; r++) begin
            thr_hi_i = 8'(hi_t[r]);
            thr_lo_i = 8'(lo_t[r]);
            run_result(10'(s0_t[r]), 10'(s1_t[r]), 10'(s2_t[r]), 10'(s3_t[r]), t, got, ec);
            n_cmp++; if (!got || t !== 8'(tmp_t[r])) begin n_bad++; $display("FAIL alarm row %0d temp_o: got %0d (seen %0d) want %0d", r, t, got, tmp_t[r]); end
            n_cmp++; if (alarm_o !== alm_t[r]) begin n_bad++; $display("FAIL alarm row %0d alarm_o: got %b want %b", r, alarm_o, alm_t[r]); end
        end
    endtask

    task automatic test_timeout();
        int s, s2, base_v;
        bit found;
        adc_respond = 1'b0;
        adc_q.delete();
        base_v = valid_cnt;
        @(negedge clk_i);
        en_i  = 1'b1;
        found = 1'b0;
        s     = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) begin found = 1'b1; s = cyc; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL timeout first start: got none want pulse within 20 cycles"); end
        repeat (12) @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL timeout err early: got %b want 0", err_o); end
        repeat (8) @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL timeout err set: got %b want 1", err_o); end
        found = 1'b0;
        s2    = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) begin found = 1'b1; s2 = cyc; end
        end
        n_cmp++; if (!found || s2 - s != 3 * CLK_DIV) begin n_bad++; $display("FAIL timeout restart spacing: got %0d (seen %0d) want %0d", s2 - s, found, 3 * CLK_DIV); end
        repeat (20) @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL timeout err sticky: got %b want 1", err_o); end
        n_cmp++; if (valid_cnt != base_v) begin n_bad++; $display("FAIL timeout valid pulses: got %0d want 0", valid_cnt - base_v); end
        n_cmp++; if (temp_o !== 8'd82) begin n_bad++; $display("FAIL timeout temp hold: got %0d want 82", temp_o); end
        en_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL timeout err clear on disable: got %b want 0", err_o); end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_abort();
        int         seen, base_s, base_v, ec;
        logic [7:0] t;
        bit         got;
        adc_respond = 1'b1;
        adc_q.delete();
        adc_q.push_back(10'd1023);
        adc_q.push_back(10'd1023);
        adc_q.push_back(10'd1023);
        base_v = valid_cnt;
        @(negedge clk_i);
        en_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 60 && seen < 3; i++) begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) seen++;
        end
        n_cmp++; if (seen != 3) begin n_bad++; $display("FAIL abort third start: got %0d starts want 3", seen); end
        // One cycle after the third start the FSM is in CONV.
        @(negedge clk_i);
        en_i   = 1'b0;
        base_s = start_q.size();
        repeat (30) @(negedge clk_i);
        n_cmp++; if (start_q.size() != base_s) begin n_bad++; $display("FAIL abort start after disable: got %0d pulses want 0", start_q.size() - base_s); end
        n_cmp++; if (temp_o !== 8'd82) begin n_bad++; $display("FAIL abort temp hold: got %0d want 82", temp_o); end
        n_cmp++; if (valid_cnt != base_v) begin n_bad++; $display("FAIL abort valid pulses: got %0d want 0", valid_cnt - base_v); end
        thr_hi_i = 8'd30;
        thr_lo_i = 8'd10;
        run_result(10'd100, 10'd200, 10'd300, 10'd400, t, got, ec);
        n_cmp++; if (!got || t !== 8'd40) begin n_bad++; $display("FAIL abort fresh average temp_o: got %0d (seen %0d) want 40", t, got); end
        n_cmp++; if (alarm_o !== 1'b1) begin n_bad++; $display("FAIL abort alarm_o: got %b want 1", alarm_o); end
    endtask

    task automatic test_reset_mid_conv();
        bit found;
        adc_respond = 1'b0;
        adc_q.delete();
        @(negedge clk_i);
        en_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) found = 1'b1;
        end
        repeat (20) @(negedge clk_i);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_i);
            if (adc_start_o === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid second start: got none want pulse"); end
        repeat (2) @(negedge clk_i);
        n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL rstmid err before reset: got %b want 1", err_o); end
        n_cmp++; if (dut.state_q !== ST_CONV) begin n_bad++; $display("FAIL rstmid state before reset: got %0d want CONV", dut.state_q); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (adc_start_o !== 1'b0) begin n_bad++; $display("FAIL rstmid adc_start_o: got %b want 0", adc_start_o); end
        n_cmp++; if (temp_o !== 8'd0) begin n_bad++; $display("FAIL rstmid temp_o: got %0d want 0", temp_o); end
        n_cmp++; if (temp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid temp_valid_o: got %b want 0", temp_valid_o); end
        n_cmp++; if (alarm_o !== 1'b0) begin n_bad++; $display("FAIL rstmid alarm_o: got %b want 0", alarm_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rstmid err_o: got %b want 0", err_o); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL rstmid state: got %0d want IDLE", dut.state_q); end
        repeat (2) @(negedge clk_i);
        en_i   = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_averaging();
        test_alarm();
        test_timeout();
        test_abort();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_temp_sample_ctrl
